mat_stream_loader: RTL and testbench

Double-buffered matrix assembler in front of the combinational `MatMul` stage. It accepts a row-major stream of `fixed` elements over a valid/ready handshake and packs them into a `ROWS`×`COLS` matrix. It presents each completed matrix, stable, on a parallel output port with its own valid/ready handshake, ready to drive the `lhs` or `rhs` input of `MatMul`. Two banks let the next matrix stream in while the current one is held for the consumer.

---
 rtl/mat_stream_loader.sv | 74 +++++++
 tb/tb_mat_stream_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_loader.sv
// mat_stream_loader: double-buffered assembler of a row-major element stream into a parallel matrix
package fixed_pkg;
  localparam int FIXED_W = 16;
  localparam int FIXED_FRAC = 8;
  typedef logic signed [FIXED_W-1:0] fixed;
endpackage

module mat_stream_loader
  import fixed_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  fixed                            in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output fixed [ROWS-1:0][COLS-1:0]       out_mat,
  output logic                            frame_err
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  fixed [1:0][ROWS-1:0][COLS-1:0] bank;
  logic [1:0] full;
  logic wsel, rsel;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic acc, last_pos;
  assign in_ready = !full[wsel];
  assign out_valid = full[rsel];
  assign out_mat = bank[rsel];
  assign acc = in_valid && in_ready;
  assign last_pos = row == RW'(ROWS-1) && col == CW'(COLS-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
      full <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      row <= '0;
      col <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (out_valid && out_ready) begin
        full[rsel] <= 1'b0;
        rsel <= ~rsel;
      end
      if (acc) begin
        bank[wsel][row][col] <= in_data;
        if (last_pos) begin
          full[wsel] <= 1'b1;
          wsel <= ~wsel;
          row <= '0;
          col <= '0;
          frame_err <= !in_last;
        end else if (in_last) begin
          row <= '0;
          col <= '0;
          frame_err <= 1'b1;
        end else if (col == CW'(COLS-1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mat_stream_loader.sv
// tb_mat_stream_loader: randomized scoreboard bench for mat_stream_loader
module tb_mat_stream_loader;
  import fixed_pkg::*;
  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int N = ROWS * COLS;
  typedef fixed [ROWS-1:0][COLS-1:0] mat_t;

  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  fixed in_data = '0;
  logic in_ready, out_valid, frame_err;
  mat_t out_mat;

  mat_stream_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_mat(out_mat),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, errs = 0, stalls = 0;
  logic rnd_or = 0;
  mat_t q[$];
  fixed cur[$];
  logic err_pend = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic fixed q8(input int v);
    return fixed'(v <<< FIXED_FRAC);
  endfunction

  function automatic mat_t seq_mat(input int base);
    mat_t m;
    for (int i = 0; i < N; i++) m[i / COLS][i % COLS] = q8(base + i);
    return m;
  endfunction

  // reference model: counts accepted elements per frame, emits whole matrices in arrival order
  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
      q.delete();
      err_pend = 0;
    end else begin
      chk("frame_err", frame_err, err_pend);
      if (frame_err) errs++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else chk("out_mat", out_mat, q.pop_front());
      end
      err_pend = 0;
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (cur.size() == N) begin
          mat_t m;
          for (int i = 0; i < N; i++) m[i / COLS][i % COLS] = cur[i];
          q.push_back(m);
          err_pend = !in_last;
          cur.delete();
        end else if (in_last) begin
          err_pend = 1;
          cur.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_or) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input fixed d, input logic l);
    int n = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic send_seq(input int base, input int cnt, input logic last_at_end);
    for (int i = 0; i < cnt; i++) send(q8(base + i), last_at_end && i == cnt - 1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", n < 100, 1);
    out_ready = 0;
  endtask

  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_out_mat", out_mat, 0);
    @(posedge clk);
    #1;

    send_seq(1, 8, 0);
    in_valid = 1;
    in_data = q8(9);
    in_last = 1;
    @(negedge clk);
    chk("pre_out_valid", out_valid, 0);
    chk("pre_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    chk("latency_out_valid", out_valid, 1);
    chk("first_mat", out_mat, seq_mat(1));
    chk("still_ready", in_ready, 1);

    send_seq(10, 9, 1);
    in_valid = 1;
    in_data = q8(19);
    in_last = 0;
    repeat (3) @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("held_mat", out_mat, seq_mat(1));
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("switch_mat", out_mat, seq_mat(10));
    chk("switch_valid", out_valid, 1);
    chk("release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send_seq(20, 8, 1);
    drain();

    out_ready = 1;
    stalls = 0;
    for (int f = 0; f < 20; f++)
      for (int i = 0; i < N; i++) send(fixed'($urandom), i == N - 1);
    chk("b2b_stalls", stalls, 0);
    drain();

    out_ready = 1;
    e0 = errs;
    send_seq(40, 5, 1);
    send_seq(50, 9, 1);
    drain();
    chk("early_last_pulses", errs - e0, 1);
    e0 = errs;
    send_seq(60, 9, 0);
    drain();
    chk("missing_last_pulses", errs - e0, 1);

    send_seq(70, 9, 1);
    send_seq(80, 8, 0);
    out_ready = 1;
    send(q8(88), 1);
    out_ready = 0;
    drain();

    rnd_or = 1;
    for (int f = 0; f < 30; f++)
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) @(posedge clk);
        #0 send(fixed'($urandom), i == N - 1 || $urandom_range(0, 40) == 0);
      end
    rnd_or = 0;
    @(posedge clk);
    #1 drain();

    send_seq(100, 9, 1);
    send_seq(110, 4, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_mat", out_mat, 0);
    chk("midrst_in_ready", in_ready, 1);
    send_seq(1, 9, 1);
    chk("post_rst_mat", out_mat, seq_mat(1));
    drain();

    repeat (3) @(posedge clk);
    chk("leftover", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
